// File: rtl/cache_ctrl.sv
// ============================================================================
// Module   : cache_ctrl
// Brief    : CPU-side controller for one cache set array. Handles compare
//            accesses, dirty write-back and word-by-word refill from memory.
//            Optional hit/miss counters enabled by defining CACHE_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_ctrl #(
  parameter int  INDEX_W = 3,
  localparam int AW      = 5 + INDEX_W + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_write,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [15:0]        cpu_wdata,
  output logic               cpu_busy,
  output logic               cpu_done,
  output logic [15:0]        cpu_rdata,
  output logic               set_enable,
  output logic [INDEX_W-1:0] set_index,
  output logic [1:0]         set_word,
  output logic               set_comp,
  output logic               set_write,
  output logic [4:0]         set_tag,
  output logic [15:0]        set_data,
  output logic               set_valid,
  input  logic               set_hit,
  input  logic               set_dirty,
  input  logic [4:0]         set_tag_out,
  input  logic [15:0]        set_data_out,
  input  logic               set_valid_out,
  output logic               mem_req,
  output logic               mem_write,
  output logic [AW-1:0]      mem_addr,
  output logic [15:0]        mem_wdata,
  input  logic [15:0]        mem_rdata,
`ifdef CACHE_STATS_EN
  input  logic               mem_ready,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
`else
  input  logic               mem_ready
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_WB      = 3'd2,
    S_ALLOC   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [1:0]         r_cnt;
  logic               r_write;
  logic [4:0]         r_tag;
  logic [INDEX_W-1:0] r_index;
  logic [1:0]         r_word;
  logic [15:0]        r_wdata;
  logic               r_done;
  logic [15:0]        r_rdata;

  logic w_hit;
  logic w_last;

  assign w_hit     = set_hit & set_valid_out;
  assign w_last    = (r_cnt == 2'd3);
  assign cpu_busy  = (r_state != S_IDLE);
  assign cpu_done  = r_done;
  assign cpu_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_write <= 1'b0;
      r_tag   <= 5'd0;
      r_index <= '0;
      r_word  <= 2'd0;
      r_wdata <= 16'd0;
      r_done  <= 1'b0;
      r_rdata <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_write <= cpu_write;
            r_tag   <= cpu_addr[AW-1:AW-5];
            r_index <= cpu_addr[INDEX_W+1:2];
            r_word  <= cpu_addr[1:0];
            r_wdata <= cpu_wdata;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            r_rdata <= set_data_out;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= 2'd0;
            r_state <= (set_valid_out && set_dirty) ? S_WB : S_ALLOC;
          end
        end
        // The counter wraps 3->0 on the same edge that leaves the state.
        S_WB: begin
          if (mem_ready) begin
            r_cnt <= r_cnt + 2'd1;
            if (w_last) r_state <= S_ALLOC;
          end
        end
        S_ALLOC: begin
          if (mem_ready) begin
            r_cnt <= r_cnt + 2'd1;
            if (w_last) r_state <= S_COMPARE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Set and memory strobes decode from state so reset clears them at once;
  // the fill write must land in the same cycle as mem_ready.
  always_comb begin
    set_enable = 1'b0;
    set_index  = '0;
    set_word   = 2'd0;
    set_comp   = 1'b0;
    set_write  = 1'b0;
    set_tag    = 5'd0;
    set_data   = 16'd0;
    set_valid  = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 16'd0;
    case (r_state)
      S_COMPARE: begin
        set_enable = 1'b1;
        set_comp   = 1'b1;
        set_write  = r_write;
        set_index  = r_index;
        set_word   = r_word;
        set_tag    = r_tag;
        set_data   = r_wdata;
      end
      S_WB: begin
        set_enable = 1'b1;
        set_index  = r_index;
        set_word   = r_cnt;
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {set_tag_out, r_index, r_cnt};
        mem_wdata  = set_data_out;
      end
      S_ALLOC: begin
        mem_req  = 1'b1;
        mem_addr = {r_tag, r_index, r_cnt};
        if (mem_ready) begin
          set_enable = 1'b1;
          set_write  = 1'b1;
          set_valid  = 1'b1;
          set_index  = r_index;
          set_word   = r_cnt;
          set_tag    = r_tag;
          set_data   = mem_rdata;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic        r_first;

  // Only the first compare of a request counts; the post-fill retry does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= 16'd0;
      r_miss_cnt <= 16'd0;
      r_first    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && cpu_req) begin
        r_first <= 1'b1;
      end else if (r_state == S_COMPARE) begin
        r_first <= 1'b0;
        if (r_first) begin
          if (w_hit) begin
            if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
          end else begin
            if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
          end
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
// ============================================================================
// Module   : tb_cache_ctrl
// Brief    : Scoreboard bench for cache_ctrl with a set-array stub, a memory
//            responder and a transparent-memory reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cache_ctrl;
  localparam int INDEX_W = 3;
  localparam int AW      = 5 + INDEX_W + 2;
  localparam int NLINE   = 1 << INDEX_W;
  localparam int NWORD   = 1 << AW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cpu_req = 1'b0;
  logic               cpu_write = 1'b0;
  logic [AW-1:0]      cpu_addr = '0;
  logic [15:0]        cpu_wdata = 16'd0;
  logic               cpu_busy, cpu_done;
  logic [15:0]        cpu_rdata;
  logic               set_enable, set_comp, set_write, set_valid;
  logic [INDEX_W-1:0] set_index;
  logic [1:0]         set_word;
  logic [4:0]         set_tag;
  logic [15:0]        set_data;
  logic               set_hit, set_dirty, set_valid_out;
  logic [4:0]         set_tag_out;
  logic [15:0]        set_data_out;
  logic               mem_req, mem_write;
  logic [AW-1:0]      mem_addr;
  logic [15:0]        mem_wdata;
  logic [15:0]        mem_rdata = 16'd0;
  logic               mem_ready = 1'b0;

  cache_ctrl #(.INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .set_enable(set_enable), .set_index(set_index), .set_word(set_word), .set_comp(set_comp),
    .set_write(set_write), .set_tag(set_tag), .set_data(set_data), .set_valid(set_valid),
    .set_hit(set_hit), .set_dirty(set_dirty), .set_tag_out(set_tag_out),
    .set_data_out(set_data_out), .set_valid_out(set_valid_out),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Set array stub: combinational read, clocked write, valid cleared on reset.
  logic [4:0]  s_tag   [NLINE];
  logic        s_val   [NLINE];
  logic        s_dirty [NLINE];
  logic [15:0] s_data  [NLINE][4];

  assign set_tag_out   = s_tag[set_index];
  assign set_valid_out = s_val[set_index];
  assign set_dirty     = s_dirty[set_index];
  assign set_data_out  = s_data[set_index][set_word];
  assign set_hit       = (s_tag[set_index] == set_tag);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NLINE; i++) begin
        s_val[i]   <= 1'b0;
        s_dirty[i] <= 1'b0;
        s_tag[i]   <= 5'd0;
      end
    end else if (set_enable && set_write) begin
      if (set_comp) begin
        if (set_hit && s_val[set_index]) begin
          s_data[set_index][set_word] <= set_data;
          s_dirty[set_index]          <= 1'b1;
        end
      end else begin
        s_data[set_index][set_word] <= set_data;
        s_tag[set_index]            <= set_tag;
        s_val[set_index]            <= set_valid;
        s_dirty[set_index]          <= 1'b0;
      end
    end
  end

  // Main memory responder: one-cycle ready pulse after a programmable wait.
  logic [15:0] main_mem [NWORD];
  int  mem_delay  = 0;
  bit  rand_delay = 1'b0;
  int  wcnt       = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_req) begin
      if (wcnt >= mem_delay) begin
        mem_ready = 1'b1;
        wcnt      = 0;
        if (mem_write) main_mem[mem_addr] = mem_wdata;
        else           mem_rdata = main_mem[mem_addr];
        if (rand_delay) mem_delay = $urandom_range(0, 3);
      end else begin
        wcnt++;
      end
    end
  end

  // Reference: the cache is transparent, so every read returns the latest CPU
  // value; residency only decides how much memory traffic a request costs.
  logic [15:0] ref_mem [NWORD];
  logic [4:0]  m_tag   [NLINE];
  bit          m_val   [NLINE];
  bit          m_dirty [NLINE];

  typedef struct {
    bit            wr;
    logic [15:0]   rdata;
    int            ops;
    bit            hit;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sbq[$];

  // Monitor
  bit            acc_prev  = 1'b0;
  int            lat       = 0;
  int            ops       = 0;
  logic          prev_req  = 1'b0;
  logic          prev_rdy  = 1'b0;
  logic          prev_wr   = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   prev_wd   = 16'd0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      acc_prev = 1'b0;
      prev_req = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (acc_prev) begin
        lat = 0;
        ops = 0;
      end
      lat++;
      if (prev_req && !prev_rdy && mem_req) begin
        check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
        check("mem_write_stable", 32'(mem_write), 32'(prev_wr));
        if (mem_write) check("mem_wdata_stable", 32'(mem_wdata), 32'(prev_wd));
      end
      if (mem_req) check("busy_during_mem", 32'(cpu_busy), 32'd1);
      if (mem_req && mem_ready) begin
        ops++;
        if (mem_write)
          check("writeback_data", 32'(mem_wdata), 32'(ref_mem[mem_addr]));
        else if (sbq.size() > 0)
          check("fill_block_addr", 32'(mem_addr[AW-1:2]), 32'(sbq[0].addr[AW-1:2]));
      end
      if (cpu_done) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending request at %0t", $time);
        end else begin
          e = sbq.pop_front();
          check("mem_ops", 32'(ops), 32'(e.ops));
          if (!e.wr) check("read_data", 32'(cpu_rdata), 32'(e.rdata));
          if (e.hit) check("hit_latency", 32'(lat), 32'd2);
        end
      end
      prev_req  = mem_req;
      prev_rdy  = mem_ready;
      prev_wr   = mem_write;
      prev_addr = mem_addr;
      prev_wd   = mem_wdata;
      acc_prev  = cpu_req && !cpu_busy;
    end
  end

  // Called at posedge+1; predicts the outcome, then presents one request.
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [15:0] d,
                       input bit wait_done, output int exp_ops);
    exp_t       e;
    int         idx;
    logic [4:0] tg;
    int         guard;
    tg     = a[AW-1:AW-5];
    idx    = int'(a[INDEX_W+1:2]);
    e.wr   = wr;
    e.addr = a;
    e.hit  = m_val[idx] && (m_tag[idx] == tg);
    e.ops  = 0;
    if (!e.hit) begin
      e.ops        = (m_val[idx] && m_dirty[idx]) ? 8 : 4;
      m_val[idx]   = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      ref_mem[a]   = d;
    end
    e.rdata = ref_mem[a];
    exp_ops = e.ops;
    guard   = 0;
    while (cpu_busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    sbq.push_back(e);
    cpu_req   = 1'b1;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (wait_done) begin
      guard = 0;
      while (sbq.size() != 0 && guard < 3000) begin
        @(posedge clk); #1;
        guard++;
      end
      if (sbq.size() != 0) begin
        total++;
        bad++;
        $display("FAIL request_timeout: got no done for addr %0h expected done within 3000 cycles", a);
        sbq.delete();
      end
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int            xo;
    int            target;
    int            guard;
    logic [4:0]    tg;
    logic [2:0]    ix;
    logic [1:0]    wd;
    logic [AW-1:0] ra;
    for (int i = 0; i < NWORD; i++) begin
      main_mem[i] = 16'($urandom);
      ref_mem[i]  = main_mem[i];
    end
    for (int i = 0; i < NLINE; i++) begin
      m_val[i]   = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 5'd0;
    end

    repeat (3) @(negedge clk);
    check("rst_cpu_busy", 32'(cpu_busy), 32'd0);
    check("rst_cpu_done", 32'(cpu_done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_set_enable", 32'(set_enable), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold fill, hit, write hit, read-back, dirty eviction, refetch of evicted data
    issue(1'b0, 10'h0A4, 16'h0, 1'b1, xo);
    issue(1'b0, 10'h0A4, 16'h0, 1'b1, xo);
    issue(1'b1, 10'h0A5, 16'hBEEF, 1'b1, xo);
    issue(1'b0, 10'h0A5, 16'h0, 1'b1, xo);
    issue(1'b0, 10'h1A4, 16'h0, 1'b1, xo);
    issue(1'b0, 10'h0A5, 16'h0, 1'b1, xo);

    // Slow memory: every word waits 5 cycles
    mem_delay = 5;
    issue(1'b0, 10'h2B8, 16'h0, 1'b1, xo);
    issue(1'b1, 10'h2B9, 16'h1234, 1'b1, xo);
    issue(1'b0, 10'h3B8, 16'h0, 1'b1, xo);
    mem_delay = 0;

    rand_delay = 1'b1;
    for (int n = 0; n < 200; n++) begin
      tg = 5'($urandom_range(0, 3));
      ix = 3'($urandom);
      wd = 2'($urandom);
      issue(($urandom_range(0, 9) < 4), {tg, ix, wd}, 16'($urandom), 1'b1, xo);
    end
    rand_delay = 1'b0;
    mem_delay  = 1;

    // Reset while the fill is on word 2
    ra = {5'd31, 3'd2, 2'd2};
    issue(1'b0, ra, 16'h0, 1'b0, xo);
    target = xo - 2;
    guard  = 0;
    while (ops < target && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    check("reached_alloc_word2", 32'(ops >= target), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_set_enable", 32'(set_enable), 32'd0);
    check("midrst_cpu_busy", 32'(cpu_busy), 32'd0);
    check("midrst_cpu_done", 32'(cpu_done), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    sbq.delete();
    for (int i = 0; i < NWORD; i++) ref_mem[i] = main_mem[i];
    for (int i = 0; i < NLINE; i++) begin
      m_val[i]   = 1'b0;
      m_dirty[i] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, ra, 16'h0, 1'b1, xo);
    check("refetch_after_reset", 32'(xo), 32'd4);
    issue(1'b0, ra, 16'h0, 1'b1, xo);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
